idecode: RTL and testbench
==========================

Name: idecode

Overview:
- Instruction decode stage; consumes nPC/IR from the IF/ID buffer and drives PCSrc/BrDest back to fetch, closing the fetch–decode loop.
- Contains a 32x`WORD register file with write-back bypass, main control decode, load-use and branch hazard detection, early branch/jump resolution, and the ID/EX pipeline buffer.
- Sits between fetch and execute; write-back feeds it from the WB stage.

Parameters:
- NREG, 32, number of architectural registers; reg 0 hardwired to zero.
- WORD, `WORD (32), datapath width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- nPC_id  in  WORD  PC+STEP of the instruction in ID (word addressed, STEP=1).
- IR_id  in  WORD  instruction in ID.
- wb_en  in  1  register write enable from WB.
- wb_addr  in  5  WB destination register.
- wb_data  in  WORD  WB write data.
- mem_RegWrite  in  1  EX/MEM instruction writes a register.
- mem_dst  in  5  EX/MEM destination register.
- PCSrc  out  1  1 = fetch takes BrDest next cycle.
- BrDest  out  WORD  branch/jump target.
- Stall  out  1  1 = fetch holds PC and IF/ID.
- ex_ctrl  out  9  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0], Branch-unused=0} registered.
- ex_rs_data, ex_rt_data  out  WORD  registered operands.
- ex_imm  out  WORD  registered sign-extended imm16.
- ex_rs, ex_rt, ex_rd  out  5 each  registered register fields.
- ex_nPC  out  WORD  registered nPC.

Behaviour:
- Reset (reset==0 at posedge): all 32 registers = 0; all ex_* outputs = 0 (bubble). PCSrc, BrDest, Stall are combinational from IR_id, so are 0 while IR_id = 0 (nop).
- Register file: write at posedge when wb_en && wb_addr!=0. Read is combinational; if wb_en && wb_addr==src && src!=0, wb_data is bypassed. Reg 0 reads 0 always.
- Decode: R-type (op 0; funct add/sub/and/or/slt) -> RegWrite, RegDst, ALUOp=10. lw (0x23) -> RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp=00. sw (0x2B) -> MemWrite, ALUSrc, ALUOp=00. addi (0x08) -> RegWrite, ALUSrc, ALUOp=00. beq (0x04)/bne (0x05)/j (0x02) -> no ex_ctrl bits set. Any other opcode -> all-zero control (treated as nop).
- Load-use stall: ex_ctrl.MemRead && ex_rt!=0 && ex_rt in {rs, rt of IR_id} -> Stall=1.
- Branch stall: beq/bne when any source register (rs or rt, non-zero) matches an ID/EX destination with RegWrite (ex_rd if RegDst else ex_rt) or mem_dst with mem_RegWrite -> Stall=1.
- On Stall: PCSrc=0; ID/EX loads the bubble (ex_ctrl=0; data fields don't-care, driven 0); IF/ID is held by fetch, so the instruction is re-presented next cycle.
- Branch resolve (no stall): beq taken if rs_data==rt_data; bne taken if not equal. Taken -> PCSrc=1, BrDest = nPC_id + sext(imm16), using 32-bit wrap-around add. j -> PCSrc=1, BrDest = {nPC_id[31:26], IR_id[25:0]}.
- Delay slot: the instruction fetched concurrently with the branch is executed; no flush.
- Latency: ID/EX outputs update 1 cycle after IR_id; branch redirect takes effect on the next fetch edge.
- Simultaneous events: a WB write to a source register in the same cycle is visible through the bypass. A load-use hit and a branch-stall hit both give a single Stall. Reset dominates stall and write.

Decomposition:
- Shared definitions header (alongside `WORD): opcode/funct constants, ALUOp encodings, and ex_ctrl bit positions.
- One natural sub-module: regfile (32x WORD, 2 read ports, 1 write port with bypass, synchronous active-low clear).
- Control decode, hazard logic and the ID/EX register live in idecode.

Test Plan:
- Reset: hold reset=0 two cycles -> all ex_* = 0, reading any register gives 0. Then WB write r5=0x1234 -> a later add r6,r5,r0 shows ex_rs_data=0x1234.
- Bypass: wb_en=1, wb_addr=3, wb_data=0xAA in the same cycle as an ID instruction reading r3 -> ex_rs_data=0xAA. Writing r0 -> read stays 0.
- Load-use: lw r2,0(r1) followed by add r4,r2,r3 -> Stall=1 for exactly one cycle with ex_ctrl=0 bubble, then the add is issued with RegWrite=1.
- Branch taken: r1=r2=7, beq r1,r2,+4 at nPC=0x10 -> PCSrc=1, BrDest=0x14. bne on the same values -> PCSrc=0.
- Negative offset/jump: beq with imm=0xFFFE, nPC=0x10 -> BrDest=0x0E. j 0x3FFFFFF with nPC=0x40000000 -> BrDest=0x43FFFFFF.
- Branch hazard: addi r1,r1,1 immediately before beq r1,r0 -> Stall for 1 cycle (ID/EX match), then 1 more cycle (mem_dst match), then resolve with the bypassed WB value.

Source files
------------

// File: rtl/idecode_pkg.sv
// Shared decode-stage definitions: widths, opcode/funct values, ALUOp codes,
// ex_ctrl bit positions and the immediate sign-extension helper.
package idecode_pkg;

  localparam int WORD = 32;
  localparam int NREG = 32;

  // Primary opcodes understood by the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALUOp encodings handed to execute
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // Bit positions inside the 9-bit ex_ctrl word
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUOP_HI = 2;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_BRANCH   = 0;

  // Sign-extend a 16-bit immediate to the datapath width
  function automatic logic [WORD-1:0] sext16(input logic [15:0] imm);
    return {{(WORD-16){imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/idecode_regfile.sv
// 32-entry register file: two combinational read ports with write-back
// bypass, one write port, register 0 hardwired to zero, synchronous clear.
module idecode_regfile
  import idecode_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [4:0]      ra1_i,
  input  logic [4:0]      ra2_i,
  output logic [WORD-1:0] rd1_o,
  output logic [WORD-1:0] rd2_o,
  input  logic            we_i,
  input  logic [4:0]      wa_i,
  input  logic [WORD-1:0] wd_i
);

  logic [WORD-1:0] regs_q [NREG];

  // Storage update: clear everything on reset, otherwise accept WB writes to r1..r31
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {WORD{1'b0}};
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read port 1: zero for r0, bypass a same-cycle WB write, else stored value
  always_comb begin
    rd1_o = {WORD{1'b0}};
    if (ra1_i == 5'd0) begin
      rd1_o = {WORD{1'b0}};
    end else if (we_i && (wa_i == ra1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = regs_q[ra1_i];
    end
  end

  // Read port 2: same policy as port 1
  always_comb begin
    rd2_o = {WORD{1'b0}};
    if (ra2_i == 5'd0) begin
      rd2_o = {WORD{1'b0}};
    end else if (we_i && (wa_i == ra2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = regs_q[ra2_i];
    end
  end

endmodule

// File: rtl/idecode.sv
// Instruction decode stage: control decode, load-use and branch hazard
// detection, early branch/jump resolution and the ID/EX pipeline register.
module idecode
  import idecode_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] nPC_id,
  input  logic [WORD-1:0] IR_id,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [WORD-1:0] wb_data,
  input  logic            mem_RegWrite,
  input  logic [4:0]      mem_dst,
  output logic            PCSrc,
  output logic [WORD-1:0] BrDest,
  output logic            Stall,
  output logic [8:0]      ex_ctrl,
  output logic [WORD-1:0] ex_rs_data,
  output logic [WORD-1:0] ex_rt_data,
  output logic [WORD-1:0] ex_imm,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [WORD-1:0] ex_nPC
);

  logic [5:0]      op_s, funct_s;
  logic [4:0]      rs_s, rt_s, rd_s;
  logic [15:0]     imm16_s;
  logic            unused_shamt_s;
  logic [WORD-1:0] rs_data_s, rt_data_s;
  logic [8:0]      ctrl_s;
  logic            is_beq_s, is_bne_s, is_j_s;
  logic            load_use_s, br_hazard_s, stall_s;
  logic [4:0]      ex_dst_s;

  logic [8:0]      ex_ctrl_d, ex_ctrl_q;
  logic [WORD-1:0] ex_rs_data_d, ex_rs_data_q, ex_rt_data_d, ex_rt_data_q;
  logic [WORD-1:0] ex_imm_d, ex_imm_q, ex_nPC_d, ex_nPC_q;
  logic [4:0]      ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q, ex_rd_d, ex_rd_q;

  assign op_s           = IR_id[31:26];
  assign rs_s           = IR_id[25:21];
  assign rt_s           = IR_id[20:16];
  assign rd_s           = IR_id[15:11];
  assign funct_s        = IR_id[5:0];
  assign imm16_s        = IR_id[15:0];
  assign unused_shamt_s = ^IR_id[10:6];

  idecode_regfile u_regfile (
    .clk_i    (clk),
    .reset_ni (reset),
    .ra1_i    (rs_s),
    .ra2_i    (rt_s),
    .rd1_o    (rs_data_s),
    .rd2_o    (rt_data_s),
    .we_i     (wb_en),
    .wa_i     (wb_addr),
    .wd_i     (wb_data)
  );

  // Main control decode; anything unrecognised becomes an all-zero nop
  always_comb begin
    ctrl_s   = 9'd0;
    is_beq_s = 1'b0;
    is_bne_s = 1'b0;
    is_j_s   = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            ctrl_s[CTRL_REGWRITE] = 1'b1;
            ctrl_s[CTRL_REGDST]   = 1'b1;
            ctrl_s[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_RTYPE;
          end
          default: ctrl_s = 9'd0;
        endcase
      end
      OP_LW: begin
        ctrl_s[CTRL_REGWRITE] = 1'b1;
        ctrl_s[CTRL_MEMTOREG] = 1'b1;
        ctrl_s[CTRL_MEMREAD]  = 1'b1;
        ctrl_s[CTRL_ALUSRC]   = 1'b1;
        ctrl_s[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl_s[CTRL_MEMWRITE] = 1'b1;
        ctrl_s[CTRL_ALUSRC]   = 1'b1;
        ctrl_s[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
      end
      OP_ADDI: begin
        ctrl_s[CTRL_REGWRITE] = 1'b1;
        ctrl_s[CTRL_ALUSRC]   = 1'b1;
        ctrl_s[CTRL_ALUOP_HI:CTRL_ALUOP_LO] = ALUOP_ADD;
      end
      OP_BEQ:  is_beq_s = 1'b1;
      OP_BNE:  is_bne_s = 1'b1;
      OP_J:    is_j_s   = 1'b1;
      default: ctrl_s = 9'd0;
    endcase
  end

  assign ex_dst_s = ex_ctrl_q[CTRL_REGDST] ? ex_rd_q : ex_rt_q;

  // Hazard detection: a load feeding ID, or a branch whose operands are still in flight
  always_comb begin
    load_use_s  = ex_ctrl_q[CTRL_MEMREAD] && (ex_rt_q != 5'd0) &&
                  ((ex_rt_q == rs_s) || (ex_rt_q == rt_s));
    br_hazard_s = 1'b0;
    if (is_beq_s || is_bne_s) begin
      br_hazard_s =
        ((rs_s != 5'd0) && ((ex_ctrl_q[CTRL_REGWRITE] && (ex_dst_s == rs_s)) ||
                            (mem_RegWrite && (mem_dst == rs_s)))) ||
        ((rt_s != 5'd0) && ((ex_ctrl_q[CTRL_REGWRITE] && (ex_dst_s == rt_s)) ||
                            (mem_RegWrite && (mem_dst == rt_s))));
    end else begin
      br_hazard_s = 1'b0;
    end
    stall_s = load_use_s || br_hazard_s;
  end

  // Early branch/jump resolution; redirect is suppressed while stalled
  always_comb begin
    PCSrc  = 1'b0;
    BrDest = {WORD{1'b0}};
    if (is_beq_s || is_bne_s) begin
      BrDest = nPC_id + sext16(imm16_s);
      PCSrc  = !stall_s && (is_beq_s ? (rs_data_s == rt_data_s)
                                     : (rs_data_s != rt_data_s));
    end else if (is_j_s) begin
      BrDest = {nPC_id[31:26], IR_id[25:0]};
      PCSrc  = !stall_s;
    end else begin
      PCSrc  = 1'b0;
      BrDest = {WORD{1'b0}};
    end
  end

  assign Stall = stall_s;

  // ID/EX next state: a zero bubble on stall, otherwise the decoded instruction
  always_comb begin
    ex_ctrl_d    = 9'd0;
    ex_rs_data_d = {WORD{1'b0}};
    ex_rt_data_d = {WORD{1'b0}};
    ex_imm_d     = {WORD{1'b0}};
    ex_nPC_d     = {WORD{1'b0}};
    ex_rs_d      = 5'd0;
    ex_rt_d      = 5'd0;
    ex_rd_d      = 5'd0;
    if (!stall_s) begin
      ex_ctrl_d    = ctrl_s;
      ex_rs_data_d = rs_data_s;
      ex_rt_data_d = rt_data_s;
      ex_imm_d     = sext16(imm16_s);
      ex_nPC_d     = nPC_id;
      ex_rs_d      = rs_s;
      ex_rt_d      = rt_s;
      ex_rd_d      = rd_s;
    end else begin
      ex_ctrl_d    = 9'd0;
    end
  end

  // ID/EX pipeline register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_ctrl_q    <= 9'd0;
      ex_rs_data_q <= {WORD{1'b0}};
      ex_rt_data_q <= {WORD{1'b0}};
      ex_imm_q     <= {WORD{1'b0}};
      ex_nPC_q     <= {WORD{1'b0}};
      ex_rs_q      <= 5'd0;
      ex_rt_q      <= 5'd0;
      ex_rd_q      <= 5'd0;
    end else begin
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_data_q <= ex_rs_data_d;
      ex_rt_data_q <= ex_rt_data_d;
      ex_imm_q     <= ex_imm_d;
      ex_nPC_q     <= ex_nPC_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_nPC     = ex_nPC_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;

endmodule

// File: tb/tb_idecode.sv
// Directed-vector bench for the idecode stage.
module tb_idecode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] nPC_id, IR_id, wb_data, BrDest;
  logic        wb_en, mem_RegWrite, PCSrc, Stall;
  logic [4:0]  wb_addr, mem_dst, ex_rs, ex_rt, ex_rd;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_nPC;

  int tests_run    = 0;
  int tests_failed = 0;

  // Hand-computed ex_ctrl words {RW,M2R,MR,MW,ASrc,RDst,ALUOp[1:0],Br}
  localparam logic [8:0] C_RTYPE = 9'h10C;
  localparam logic [8:0] C_LW    = 9'h1D0;
  localparam logic [8:0] C_SW    = 9'h030;
  localparam logic [8:0] C_ADDI  = 9'h110;

  idecode dut (
    .clk(clk), .reset(reset), .nPC_id(nPC_id), .IR_id(IR_id),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_RegWrite(mem_RegWrite), .mem_dst(mem_dst),
    .PCSrc(PCSrc), .BrDest(BrDest), .Stall(Stall),
    .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_nPC(ex_nPC)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    IR_id = 32'd0; wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; IR_id = 32'd0; nPC_id = 32'd0; mem_RegWrite = 1'b0; mem_dst = 5'd0;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick(); tick();
    wb_en = 1'b0;
    tests_run++;
    if (ex_ctrl !== 9'd0 || ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0 || ex_imm !== 32'd0 ||
        ex_nPC !== 32'd0 || ex_rs !== 5'd0 || ex_rt !== 5'd0 || ex_rd !== 5'd0) begin
      tests_failed++; $display("FAIL reset_ex: ctrl=%h rs_data=%h nPC=%h expected all zero", ex_ctrl, ex_rs_data, ex_nPC);
    end
    #1;
    tests_run++;
    if (PCSrc !== 1'b0 || BrDest !== 32'd0 || Stall !== 1'b0) begin
      tests_failed++; $display("FAIL reset_comb: PCSrc=%b BrDest=%h Stall=%b expected 0", PCSrc, BrDest, Stall);
    end
    reset = 1'b1;
    IR_id = rtype(5'd9, 5'd5, 5'd6, 6'h20);
    tick();
    tests_run++;
    if (ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0) begin
      tests_failed++; $display("FAIL reset_regs: rs_data=%h rt_data=%h expected 0", ex_rs_data, ex_rt_data);
    end
    wb_write(5'd5, 32'h1234);
    IR_id = rtype(5'd5, 5'd0, 5'd6, 6'h20);
    tick();
    tests_run++;
    if (ex_rs_data !== 32'h1234 || ex_rd !== 5'd6 || ex_ctrl !== C_RTYPE) begin
      tests_failed++; $display("FAIL reset_write_read: rs_data=%h rd=%0d ctrl=%h expected 1234 6 %h", ex_rs_data, ex_rd, ex_ctrl, C_RTYPE);
    end
  endtask

  task automatic test_bypass();
    IR_id = rtype(5'd3, 5'd0, 5'd7, 6'h20);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hAA;
    tick();
    wb_en = 1'b0;
    tests_run++;
    if (ex_rs_data !== 32'hAA) begin
      tests_failed++; $display("FAIL bypass_rs: got %h expected 000000aa", ex_rs_data);
    end
    IR_id = rtype(5'd0, 5'd3, 5'd8, 6'h22);
    tick();
    tests_run++;
    if (ex_rt_data !== 32'hAA || ex_rt !== 5'd3) begin
      tests_failed++; $display("FAIL bypass_stored: rt_data=%h rt=%0d expected aa 3", ex_rt_data, ex_rt);
    end
    IR_id = rtype(5'd0, 5'd0, 5'd9, 6'h25);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    tick();
    wb_en = 1'b0;
    tests_run++;
    if (ex_rs_data !== 32'd0) begin
      tests_failed++; $display("FAIL bypass_r0: got %h expected 0", ex_rs_data);
    end
    tick();
    tests_run++;
    if (ex_rs_data !== 32'd0 || ex_rt_data !== 32'd0) begin
      tests_failed++; $display("FAIL r0_stored: rs=%h rt=%h expected 0", ex_rs_data, ex_rt_data);
    end
  endtask

  task automatic test_decode();
    IR_id = itype(6'h2B, 5'd1, 5'd2, 16'h0008);
    tick();
    tests_run++;
    if (ex_ctrl !== C_SW || ex_imm !== 32'h8) begin
      tests_failed++; $display("FAIL decode_sw: ctrl=%h imm=%h expected %h 8", ex_ctrl, ex_imm, C_SW);
    end
    IR_id = itype(6'h3F, 5'd1, 5'd2, 16'h0001);
    tick();
    tests_run++;
    if (ex_ctrl !== 9'd0) begin
      tests_failed++; $display("FAIL decode_unknown_op: ctrl=%h expected 0", ex_ctrl);
    end
    IR_id = rtype(5'd1, 5'd2, 5'd3, 6'h2A);
    tick();
    tests_run++;
    if (ex_ctrl !== C_RTYPE) begin
      tests_failed++; $display("FAIL decode_slt: ctrl=%h expected %h", ex_ctrl, C_RTYPE);
    end
    IR_id = rtype(5'd1, 5'd2, 5'd3, 6'h08);
    tick();
    tests_run++;
    if (ex_ctrl !== 9'd0) begin
      tests_failed++; $display("FAIL decode_unknown_funct: ctrl=%h expected 0", ex_ctrl);
    end
  endtask

  task automatic test_load_use();
    IR_id = itype(6'h23, 5'd1, 5'd2, 16'h0000);
    tick();
    tests_run++;
    if (ex_ctrl !== C_LW || ex_rt !== 5'd2) begin
      tests_failed++; $display("FAIL lw_issue: ctrl=%h rt=%0d expected %h 2", ex_ctrl, ex_rt, C_LW);
    end
    IR_id = rtype(5'd2, 5'd3, 5'd4, 6'h20);
    #1;
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 1'b0) begin
      tests_failed++; $display("FAIL load_use_stall: Stall=%b PCSrc=%b expected 1 0", Stall, PCSrc);
    end
    tick();
    tests_run++;
    if (ex_ctrl !== 9'd0 || Stall !== 1'b0) begin
      tests_failed++; $display("FAIL load_use_bubble: ctrl=%h Stall=%b expected 0 0", ex_ctrl, Stall);
    end
    tick();
    tests_run++;
    if (ex_ctrl !== C_RTYPE || ex_rd !== 5'd4) begin
      tests_failed++; $display("FAIL load_use_reissue: ctrl=%h rd=%0d expected %h 4", ex_ctrl, ex_rd, C_RTYPE);
    end
    IR_id = 32'd0;
    tick();
  endtask

  task automatic test_branch_taken();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    tick();
    nPC_id = 32'h10;
    IR_id = itype(6'h04, 5'd1, 5'd2, 16'h0004);
    #1;
    tests_run++;
    if (PCSrc !== 1'b1 || BrDest !== 32'h14 || Stall !== 1'b0) begin
      tests_failed++; $display("FAIL beq_taken: PCSrc=%b BrDest=%h Stall=%b expected 1 14 0", PCSrc, BrDest, Stall);
    end
    IR_id = itype(6'h05, 5'd1, 5'd2, 16'h0004);
    #1;
    tests_run++;
    if (PCSrc !== 1'b0) begin
      tests_failed++; $display("FAIL bne_not_taken: PCSrc=%b expected 0", PCSrc);
    end
    IR_id = itype(6'h05, 5'd1, 5'd3, 16'h0004);
    #1;
    tests_run++;
    if (PCSrc !== 1'b1 || BrDest !== 32'h14) begin
      tests_failed++; $display("FAIL bne_taken: PCSrc=%b BrDest=%h expected 1 14", PCSrc, BrDest);
    end
    tick();
    tests_run++;
    if (ex_ctrl !== 9'd0 || ex_nPC !== 32'h10 || ex_imm !== 32'h4) begin
      tests_failed++; $display("FAIL branch_idex: ctrl=%h nPC=%h imm=%h expected 0 10 4", ex_ctrl, ex_nPC, ex_imm);
    end
  endtask

  task automatic test_neg_jump();
    nPC_id = 32'h10;
    IR_id = itype(6'h04, 5'd0, 5'd0, 16'hFFFE);
    #1;
    tests_run++;
    if (PCSrc !== 1'b1 || BrDest !== 32'h0E) begin
      tests_failed++; $display("FAIL beq_negative: PCSrc=%b BrDest=%h expected 1 0000000e", PCSrc, BrDest);
    end
    tick();
    tests_run++;
    if (ex_imm !== 32'hFFFF_FFFE) begin
      tests_failed++; $display("FAIL sext_imm: got %h expected fffffffe", ex_imm);
    end
    nPC_id = 32'h4000_0000;
    IR_id = {6'h02, 26'h3FF_FFFF};
    #1;
    tests_run++;
    if (PCSrc !== 1'b1 || BrDest !== 32'h43FF_FFFF) begin
      tests_failed++; $display("FAIL jump: PCSrc=%b BrDest=%h expected 1 43ffffff", PCSrc, BrDest);
    end
    nPC_id = 32'h0;
    IR_id = 32'd0;
    tick();
  endtask

  task automatic test_branch_hazard();
    wb_write(5'd1, 32'hFFFF_FFFF);
    nPC_id = 32'h20;
    IR_id = itype(6'h08, 5'd1, 5'd1, 16'h0001);
    tick();
    tests_run++;
    if (ex_ctrl !== C_ADDI || ex_rt !== 5'd1) begin
      tests_failed++; $display("FAIL addi_issue: ctrl=%h rt=%0d expected %h 1", ex_ctrl, ex_rt, C_ADDI);
    end
    nPC_id = 32'h21;
    IR_id = itype(6'h04, 5'd1, 5'd0, 16'h0008);
    #1;
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 1'b0) begin
      tests_failed++; $display("FAIL br_hazard_ex: Stall=%b PCSrc=%b expected 1 0", Stall, PCSrc);
    end
    tick();
    mem_RegWrite = 1'b1; mem_dst = 5'd1;
    #1;
    tests_run++;
    if (Stall !== 1'b1 || PCSrc !== 1'b0 || ex_ctrl !== 9'd0) begin
      tests_failed++; $display("FAIL br_hazard_mem: Stall=%b PCSrc=%b ctrl=%h expected 1 0 0", Stall, PCSrc, ex_ctrl);
    end
    tick();
    mem_RegWrite = 1'b0; mem_dst = 5'd0;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd0;
    #1;
    tests_run++;
    if (Stall !== 1'b0 || PCSrc !== 1'b1 || BrDest !== 32'h29) begin
      tests_failed++; $display("FAIL br_resolve_bypass: Stall=%b PCSrc=%b BrDest=%h expected 0 1 29", Stall, PCSrc, BrDest);
    end
    tick();
    wb_en = 1'b0;
    IR_id = 32'd0;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_decode();
    test_load_use();
    test_branch_taken();
    test_neg_jump();
    test_branch_hazard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
